// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU execute stage:
//   XLEN_DEFAULT  default operand/result width
//   SHAMT_W       width of the shift amount taken from op_b
//   alu_op_e      ALU operation codes produced by the ALU control decoder
//   aluState_e    execute-stage FSM states
//   isShiftOp()   true for the three shift operations
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int SHAMT_W      = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_SLL = 4'b0010,
    OP_XOR = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_OR  = 4'b1000,
    OP_AND = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } aluState_e;

  // Raw op codes are compared here so that illegal codes simply return 0.
  function automatic logic isShiftOp(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_serial.sv
// ---------------------------------------------------------------------------
// alu_shift_serial
// One-bit-per-cycle shifter with a down-counter holding the remaining steps.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   load_i        capture data_i / amount_i / op_i and start shifting
//   data_i        value to be shifted
//   amount_i      number of steps (non-zero when loaded)
//   op_i          OP_SLL, OP_SRL or OP_SRA
//   stepData_o    the shift register advanced by one more bit
//   lastStep_o    the current step is the final one (counter == 1)
// ---------------------------------------------------------------------------
module alu_shift_serial
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] amount_i,
  input  alu_op_e            op_i,
  output logic [XLEN-1:0]    stepData_o,
  output logic               lastStep_o
);

  logic [XLEN-1:0]    shiftReg_q, shiftReg_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  alu_op_e            op_q, op_d;

  // One-bit shift of the working register; SRA replicates the sign bit,
  // anything else that is not SRL is treated as a left shift.
  always_comb begin
    stepData_o = {shiftReg_q[XLEN-2:0], 1'b0};
    case (op_q)
      OP_SRL:  stepData_o = {1'b0, shiftReg_q[XLEN-1:1]};
      OP_SRA:  stepData_o = {shiftReg_q[XLEN-1], shiftReg_q[XLEN-1:1]};
      default: stepData_o = {shiftReg_q[XLEN-2:0], 1'b0};
    endcase
  end

  assign lastStep_o = (count_q == SHAMT_W'(1));

  // Load wins over stepping; the register keeps shifting while the
  // counter is non-zero and then sits idle once it reaches zero.
  always_comb begin
    shiftReg_d = shiftReg_q;
    count_d    = count_q;
    op_d       = op_q;
    if (load_i) begin
      shiftReg_d = data_i;
      count_d    = amount_i;
      op_d       = op_i;
    end else if (count_q != '0) begin
      shiftReg_d = stepData_o;
      count_d    = count_q - SHAMT_W'(1);
    end
  end

  // Reset clears the counter so an interrupted shift never completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shiftReg_q <= '0;
      count_q    <= '0;
      op_q       <= OP_SLL;
    end else begin
      shiftReg_q <= shiftReg_d;
      count_q    <= count_d;
      op_q       <= op_d;
    end
  end

endmodule

// File: rtl/alu_execute.sv
// ---------------------------------------------------------------------------
// alu_execute
// Registered ALU execute stage with valid/ready handshakes on both sides.
// Non-shift ops (and shifts by 0) complete in one cycle; shifts by N>0 use
// a serial shifter and complete after N+1 cycles, then wait in HOLD until
// the consumer takes the result.
// Build option: define ALU_FAST_SHIFT_EN to replace the serial shifter with
// a single-cycle barrel shifter (all ops then have latency 1).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   alu_operation   op code (alu_op_e encodings, others are illegal)
//   op_a, op_b      operands; shift amount is op_b[4:0]
//   in_valid/in_ready    request handshake
//   result, zero, illegal  registered outputs
//   out_valid/out_ready  result handshake
// ---------------------------------------------------------------------------
module alu_execute
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      alu_operation,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            out_valid,
  input  logic            out_ready
);

  aluState_e          state_q;
  logic [XLEN-1:0]    result_q;
  logic               zero_q;
  logic               illegal_q;
  logic               outValid_q;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    quickResult;
  logic               opLegal;
  logic               accept;
  logic               startSerial;

  assign shamt = op_b[SHAMT_W-1:0];

  // in_ready is forced low during reset so nothing is taken while the
  // state register may still hold a stale value.
  assign in_ready  = rst_n && (state_q == IDLE) && (!outValid_q || out_ready);
  assign accept    = in_valid && in_ready;

  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign out_valid = outValid_q;

  // Single-cycle datapath; shifts here use the full amount, which covers
  // both shift-by-zero and the barrel-shifter build.
  always_comb begin
    quickResult = '0;
    opLegal     = 1'b1;
    case (alu_operation)
      OP_ADD:  quickResult = op_a + op_b;
      OP_SUB:  quickResult = op_a - op_b;
      OP_SLL:  quickResult = op_a << shamt;
      OP_XOR:  quickResult = op_a ^ op_b;
      OP_SRL:  quickResult = op_a >> shamt;
      OP_SRA:  quickResult = $signed(op_a) >>> shamt;
      OP_OR:   quickResult = op_a | op_b;
      OP_AND:  quickResult = op_a & op_b;
      default: opLegal     = 1'b0;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign startSerial = 1'b0;
`else
  logic [XLEN-1:0] stepData;
  logic            lastStep;

  assign startSerial = accept && isShiftOp(alu_operation) && (shamt != '0);

  alu_shift_serial #(
    .XLEN (XLEN)
  ) uShift (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (startSerial),
    .data_i     (op_a),
    .amount_i   (shamt),
    .op_i       (alu_op_e'(alu_operation)),
    .stepData_o (stepData),
    .lastStep_o (lastStep)
  );
`endif

  // Control FSM with registered outputs. In IDLE a finished handshake and a
  // new acceptance can happen on the same edge, so a single-cycle op simply
  // overwrites the result and keeps out_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startSerial) begin
            state_q    <= SHIFT;
            outValid_q <= 1'b0;
          end else if (accept) begin
            outValid_q <= 1'b1;
            result_q   <= quickResult;
            zero_q     <= (quickResult == '0);
            illegal_q  <= !opLegal;
          end else if (out_ready) begin
            outValid_q <= 1'b0;
          end
        end
`ifdef ALU_FAST_SHIFT_EN
        SHIFT, HOLD: begin
          state_q <= IDLE;
        end
`else
        SHIFT: begin
          if (lastStep) begin
            state_q    <= HOLD;
            outValid_q <= 1'b1;
            result_q   <= stepData;
            zero_q     <= (stepData == '0);
            illegal_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_execute.sv
// ---------------------------------------------------------------------------
// tb_alu_execute
// Self-checking bench for alu_execute: reset checks, a table of directed
// vectors, hand-written handshake/reset sequences and randomized ops checked
// against a behavioural model. Works with or without ALU_FAST_SHIFT_EN.
// ---------------------------------------------------------------------------
module tb_alu_execute;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_operation;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        out_valid;
  logic        out_ready;

  int compared = 0;
  int failed   = 0;

  alu_execute #(
    .XLEN (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_operation (alu_operation),
    .op_a          (op_a),
    .op_b          (op_b),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .result        (result),
    .zero          (zero),
    .illegal       (illegal),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  // Expected latency of a shift by n.
  function automatic int shLat(input int n);
    return (FAST || n == 0) ? 1 : n + 1;
  endfunction

  // Behavioural model: plain arithmetic on the op code meaning.
  function automatic void refModel(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output logic ill, output int lat);
    int n;
    n   = int'(b % 32);
    r   = 32'h0;
    ill = 1'b0;
    lat = 1;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: begin r = a << n; lat = shLat(n); end
      4'b0101: r = a ^ b;
      4'b0110: begin r = a >> n; lat = shLat(n); end
      4'b0111: begin r = 32'($signed(a) >>> n); lat = shLat(n); end
      4'b1000: r = a | b;
      4'b1001: r = a & b;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    failed++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request, wait for acceptance, scramble the inputs so late
  // changes would show up, then count edges until out_valid appears.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] res,
                               output logic z, output logic ill,
                               output int lat, output logic readyWhileBusy);
    int guard;
    alu_operation = op;
    op_a          = a;
    op_b          = b;
    in_valid      = 1'b1;
    guard         = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) timeoutFail("in_ready_wait");
    @(posedge clk);
    #1;
    in_valid       = 1'b0;
    alu_operation  = 4'($urandom);
    op_a           = $urandom;
    op_b           = $urandom;
    lat            = 1;
    readyWhileBusy = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) readyWhileBusy = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    z   = zero;
    ill = illegal;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] res;
    logic [31:0] expRes;
    logic        z;
    logic        ill;
    logic        expIll;
    logic        busyReady;
    logic        sawValid;
    int          lat;
    int          expLat;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n         = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    alu_operation = 4'h0;
    op_a          = 32'h0;
    op_b          = 32'h0;

    // Reset state.
    idleCycles(3);
    checkOutput("rst_in_ready",  32'(in_ready),  32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_result",    result,         32'h0);
    checkOutput("rst_zero",      32'(zero),      32'h0);
    checkOutput("rst_illegal",   32'(illegal),   32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready",  32'(in_ready),  32'h1);

    // Directed vector table.
    vecs.push_back('{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1});
    vecs.push_back('{4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, shLat(4)});
    vecs.push_back('{4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1});
    vecs.push_back('{4'b0101, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b1000, 32'h00FF_0000, 32'h0000_FF00, 32'h00FF_FF00, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b1001, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b0110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, shLat(31)});
    vecs.push_back('{4'b0010, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, shLat(31)});
    vecs.push_back('{4'b0010, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1});
    vecs.push_back('{4'b0111, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 1'b0, 1'b0, shLat(1)});
    vecs.push_back('{4'b0011, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b1, 1});
    vecs.push_back('{4'b0001, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0, 1});
    vecs.push_back('{4'b0111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, shLat(31)});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, z, ill, lat, busyReady);
      checkOutput($sformatf("vec%0d_result", i),  res,        vecs[i].res);
      checkOutput($sformatf("vec%0d_zero", i),    32'(z),     32'(vecs[i].z));
      checkOutput($sformatf("vec%0d_illegal", i), 32'(ill),   32'(vecs[i].ill));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat),   32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d_busy_ready", i), 32'(busyReady), 32'h0);
    end

    // Stalled consumer: result held, in_ready low, new request taken on the
    // out_ready cycle.
    idleCycles(2);
    out_ready = 1'b0;
    applyStimulus(4'b0101, 32'hF0F0_F0F0, 32'hFFFF_0000, res, z, ill, lat, busyReady);
    checkOutput("stall_first_result", res, 32'h0F0F_F0F0);
    alu_operation = 4'b1001;
    op_a          = 32'h0000_00FF;
    op_b          = 32'h0000_000F;
    in_valid      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall%0d_result", i),    result,         32'h0F0F_F0F0);
      checkOutput($sformatf("stall%0d_out_valid", i), 32'(out_valid), 32'h1);
      checkOutput($sformatf("stall%0d_in_ready", i),  32'(in_ready),  32'h0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("stall_release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("stall_next_out_valid", 32'(out_valid), 32'h1);
    checkOutput("stall_next_result",    result,         32'h0000_000F);

    // Back-to-back acceptance with no bubble.
    idleCycles(2);
    applyStimulus(4'b0000, 32'h1, 32'h2, res, z, ill, lat, busyReady);
    checkOutput("b2b_first_result", res, 32'h3);
    checkOutput("b2b_in_ready",     32'(in_ready), 32'h1);
    alu_operation = 4'b0000;
    op_a          = 32'h3;
    op_b          = 32'h4;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("b2b_out_valid", 32'(out_valid), 32'h1);
    checkOutput("b2b_result",    result,         32'h7);
    @(posedge clk);
    #1;
    checkOutput("b2b_drop_valid", 32'(out_valid), 32'h0);

    // A finished serial shift waits in HOLD for one handshake edge.
    idleCycles(2);
    applyStimulus(4'b0110, 32'h0000_00F0, 32'h4, res, z, ill, lat, busyReady);
    checkOutput("hold_result",   res,           32'h0000_000F);
    checkOutput("hold_latency",  32'(lat),      32'(shLat(4)));
    checkOutput("hold_in_ready", 32'(in_ready), FAST ? 32'h1 : 32'h0);
    @(posedge clk);
    #1;
    checkOutput("hold_after_valid", 32'(out_valid), 32'h0);
    checkOutput("hold_after_ready", 32'(in_ready),  32'h1);

    // Reset in the middle of a long shift aborts it.
    idleCycles(2);
    alu_operation = 4'b0010;
    op_a          = 32'h1;
    op_b          = 32'd20;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idleCycles(5);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'h0);
    checkOutput("abort_result",    result,         32'h0);
    checkOutput("abort_in_ready",  32'(in_ready),  32'h1);
    sawValid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort_no_output", 32'(sawValid), 32'h0);
    applyStimulus(4'b1001, 32'h0000_00FF, 32'h0000_000F, res, z, ill, lat, busyReady);
    checkOutput("post_abort_result",  res,      32'h0000_000F);
    checkOutput("post_abort_latency", 32'(lat), 32'h1);

    // Randomized ops against the behavioural model.
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      refModel(rop, ra, rb, expRes, expIll, expLat);
      applyStimulus(rop, ra, rb, res, z, ill, lat, busyReady);
      checkOutput($sformatf("rnd%0d_result", i),  res,      expRes);
      checkOutput($sformatf("rnd%0d_zero", i),    32'(z),   32'(expRes == 32'h0));
      checkOutput($sformatf("rnd%0d_illegal", i), 32'(ill), 32'(expIll));
      checkOutput($sformatf("rnd%0d_latency", i), 32'(lat), 32'(expLat));
    end

    idleCycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
